// File: rtl/alphamission_sprite_linebuffer.sv
// -----------------------------------------------------------------------------
// alphamission_sprite_linebuffer
//
// Ping-pong sprite line buffer that feeds the 8-bit LD input of the final video
// stage. While line N is being displayed, the sprite engine writes the pixels
// for line N+1 into the write bank. At the same time the read bank streams
// line N out at pixel rate and clears each entry once it has been read. The two
// banks swap roles on every LINE_START. Each line also has a budget of
// accepted writes. Opaque writes beyond that budget are dropped, which
// reproduces the sprite-overflow behaviour of the original hardware.
//
// Ports
//   clk         system clock
//   VIDEO_RSTn  asynchronous active-low reset
//   CK1         pixel clock-enable, one clk wide, period >= 3 clk
//   LINE_START  one-clk pulse at the start of hblank; swaps the banks
//   wr_valid    sprite engine pixel write request
//   wr_ready    write accepted when wr_valid & wr_ready
//   wr_x        write address (screen x)
//   wr_data     pixel {palette[3:0], colour[3:0]}
//   LD          line buffer pixel to the final video mux
//   LD_VALID    high while a streamed pixel is on LD
//   OVF         sticky for the line: a write was dropped by the budget
// -----------------------------------------------------------------------------
module alphamission_sprite_linebuffer #(
   parameter int                 HPIX_W     = 9,
   parameter int                 DATA_W     = 8,
   parameter logic [DATA_W-1:0]  CLEAR_VAL  = 8'hFF,
   parameter logic [3:0]         TRANSP_NIB = 4'hF,
   parameter logic [HPIX_W-1:0]  RD_START   = '0,
   parameter logic [HPIX_W:0]    RD_LEN     = 10'd256,
   parameter logic [HPIX_W:0]    WR_BUDGET  = 10'd384
) (
   input  logic              clk,
   input  logic              VIDEO_RSTn,
   input  logic              CK1,
   input  logic              LINE_START,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [HPIX_W-1:0] wr_x,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] LD,
   output logic              LD_VALID,
   output logic              OVF
);

   localparam int DEPTH = 1 << HPIX_W;
   localparam int CNT_W = HPIX_W + 1;

   typedef enum logic {
      S_INIT,
      S_RUN
   } state_t;

   state_t              state;
   state_t              state_nxt;

   // Sweep address across both banks; the top bit selects the bank.
   logic [HPIX_W:0]     init_addr;

   // Line control
   logic                bank_sel;     // write bank; the read bank is ~bank_sel
   logic [HPIX_W-1:0]   rd_x;
   logic [CNT_W-1:0]    rd_cnt;
   logic                rd_active;
   logic [CNT_W-1:0]    wr_cnt;

   // Read pipeline: p1 = read issued (capture + clear pending),
   // p2 = captured (address advance pending)
   logic                vld_p1;
   logic                vld_p2;
   logic [HPIX_W-1:0]   rd_addr_p1;
   logic                rd_bank_p1;
   logic                fetch_vld;
   logic [DATA_W-1:0]   fetch_data;

   // Bank storage (not reset; the INIT sweep clears it)
   logic [DATA_W-1:0]   mem0 [DEPTH];
   logic [DATA_W-1:0]   mem1 [DEPTH];

   // Per-bank write port
   logic                we0;
   logic                we1;
   logic [HPIX_W-1:0]   wa0;
   logic [HPIX_W-1:0]   wa1;
   logic [DATA_W-1:0]   wd0;
   logic [DATA_W-1:0]   wd1;

   // Decoded strobes
   logic                run;
   logic                swap;
   logic                pix;
   logic                issue;
   logic                issue_bank;
   logic [HPIX_W-1:0]   issue_x;
   logic                clear_en;
   logic                wr_fire;
   logic                wr_opaque;
   logic                wr_commit;
   logic                wr_drop;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge VIDEO_RSTn) begin
      if (!VIDEO_RSTn) begin
         state <= S_INIT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wr_ready  = 1'b0;
      case (state)
         S_INIT: begin
            if (&init_addr) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            // No write is accepted in the swap cycle, so a write can never land
            // in a bank that is changing role.
            wr_ready = ~LINE_START;
         end
         default: state_nxt = S_INIT;
      endcase
   end

   // ---------------------------------------------------------------- decode
   always_comb begin
      run        = (state == S_RUN);
      swap       = run & LINE_START;
      pix        = run & CK1;
      // A CK1 that arrives together with the swap is the first read of the new line.
      issue      = pix & (swap | rd_active);
      issue_bank = swap ? bank_sel : ~bank_sel;
      issue_x    = swap ? RD_START : rd_x;
      // A swap cancels whatever read is still in flight from the old line.
      clear_en   = vld_p1 & ~swap;
      wr_fire    = wr_valid & wr_ready;
      wr_opaque  = (wr_data[3:0] != TRANSP_NIB);
      wr_commit  = wr_fire & wr_opaque & (wr_cnt <  WR_BUDGET);
      wr_drop    = wr_fire & wr_opaque & (wr_cnt >= WR_BUDGET);
   end

   // Bank write steering. In RUN, the sprite write always targets bank_sel.
   // The clear always targets the bank read on the previous pulse, which is
   // ~bank_sel here, so each bank sees at most one write per clk.
   always_comb begin
      we0 = 1'b0;
      we1 = 1'b0;
      wa0 = wr_x;
      wa1 = wr_x;
      wd0 = wr_data;
      wd1 = wr_data;
      if (state == S_INIT) begin
         we0 = ~init_addr[HPIX_W];
         we1 =  init_addr[HPIX_W];
         wa0 = init_addr[HPIX_W-1:0];
         wa1 = init_addr[HPIX_W-1:0];
         wd0 = CLEAR_VAL;
         wd1 = CLEAR_VAL;
      end else begin
         if (wr_commit) begin
            if (bank_sel) we1 = 1'b1;
            else          we0 = 1'b1;
         end
         if (clear_en) begin
            if (rd_bank_p1) begin
               we1 = 1'b1;
               wa1 = rd_addr_p1;
               wd1 = CLEAR_VAL;
            end else begin
               we0 = 1'b1;
               wa0 = rd_addr_p1;
               wd0 = CLEAR_VAL;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we0) mem0[wa0] <= wd0;
   end

   always_ff @(posedge clk) begin
      if (we1) mem1[wa1] <= wd1;
   end

   // ---------------------------------------------------------------- p0 -> p1 / p1 capture (datapath, no reset)
   always_ff @(posedge clk) begin
      if (issue) begin
         rd_addr_p1 <= issue_x;
         rd_bank_p1 <= issue_bank;
      end
      // The read sees the pre-clear value because the clear lands on this same edge.
      if (clear_en) begin
         fetch_data <= rd_bank_p1 ? mem1[rd_addr_p1] : mem0[rd_addr_p1];
      end
   end

   // ---------------------------------------------------------------- control
   always_ff @(posedge clk or negedge VIDEO_RSTn) begin
      if (!VIDEO_RSTn) begin
         init_addr <= '0;
         bank_sel  <= 1'b0;
         rd_x      <= '0;
         rd_cnt    <= '0;
         rd_active <= 1'b0;
         wr_cnt    <= '0;
         OVF       <= 1'b0;
         vld_p1    <= 1'b0;
         vld_p2    <= 1'b0;
         fetch_vld <= 1'b0;
         LD        <= CLEAR_VAL;
         LD_VALID  <= 1'b0;
      end else if (state == S_INIT) begin
         init_addr <= init_addr + 1'b1;
      end else if (swap) begin
         bank_sel  <= ~bank_sel;
         rd_x      <= RD_START;
         rd_cnt    <= '0;
         rd_active <= 1'b1;
         wr_cnt    <= '0;
         OVF       <= 1'b0;
         vld_p1    <= issue;
         vld_p2    <= 1'b0;
         fetch_vld <= 1'b0;
         if (pix) begin
            LD       <= CLEAR_VAL;
            LD_VALID <= 1'b0;
         end
      end else begin
         if (wr_commit) wr_cnt <= wr_cnt + 1'b1;
         if (wr_drop)   OVF    <= 1'b1;

         vld_p1 <= issue;
         vld_p2 <= vld_p1;

         // p1: captured word is now available for the next pulse
         if (vld_p1) fetch_vld <= 1'b1;

         // p0: present the pixel fetched on the previous pulse
         if (pix) begin
            LD        <= fetch_vld ? fetch_data : CLEAR_VAL;
            LD_VALID  <= fetch_vld;
            fetch_vld <= 1'b0;
         end

         // p2: advance the stream
         if (vld_p2) begin
            rd_x   <= rd_x + 1'b1;
            rd_cnt <= rd_cnt + 1'b1;
            if ((rd_cnt + 1'b1) == RD_LEN) rd_active <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alphamission_sprite_linebuffer.sv
// -----------------------------------------------------------------------------
// Directed bench for alphamission_sprite_linebuffer: INIT sweep length,
// streaming, transparency, overwrite, clear-behind-read, write budget/OVF,
// swap-cycle collisions and asynchronous reset mid-line.
// -----------------------------------------------------------------------------
module tb_alphamission_sprite_linebuffer;

   logic       clk = 1'b0;
   logic       VIDEO_RSTn;
   logic       CK1;
   logic       LINE_START;
   logic       wr_valid;
   logic       wr_ready;
   logic [8:0] wr_x;
   logic [7:0] wr_data;
   logic [7:0] LD;
   logic       LD_VALID;
   logic       OVF;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0] exp_line [256];

   always #5 clk = ~clk;

   alphamission_sprite_linebuffer dut (
      .clk        (clk),
      .VIDEO_RSTn (VIDEO_RSTn),
      .CK1        (CK1),
      .LINE_START (LINE_START),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_x       (wr_x),
      .wr_data    (wr_data),
      .LD         (LD),
      .LD_VALID   (LD_VALID),
      .OVF        (OVF)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Advance one clk; return 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int x, input logic [7:0] d);
      wr_valid = 1'b1;
      wr_x     = x[8:0];
      wr_data  = d;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic line_start();
      LINE_START = 1'b1;
      tick();
      LINE_START = 1'b0;
   endtask

   task automatic fill_ff();
      for (int i = 0; i < 256; i++) exp_line[i] = 8'hFF;
   endtask

   function automatic logic [7:0] pat(input int x);
      logic [8:0] xv;
      xv = x[8:0];
      return {xv[7:4], (xv[3:0] == 4'hF) ? 4'hE : xv[3:0]};
   endfunction

   // Pulse CK1 258 times (period 4 clk). Pulse 0 and 257 are idle; pulse k
   // (1..256) presents pixel k-1.
   task automatic stream(input string tag, input bit with_ls);
      for (int p = 0; p < 258; p++) begin
         CK1 = 1'b1;
         if (p == 0 && with_ls) LINE_START = 1'b1;
         tick();
         CK1        = 1'b0;
         LINE_START = 1'b0;
         if (p == 0 || p == 257) begin
            chk($sformatf("%s_idle%0d_ld", tag, p), {24'd0, LD}, 32'hFF);
            chk($sformatf("%s_idle%0d_vld", tag, p), {31'd0, LD_VALID}, 32'd0);
         end else begin
            chk($sformatf("%s_px%0d", tag, p - 1), {24'd0, LD}, {24'd0, exp_line[p - 1]});
            chk($sformatf("%s_px%0d_vld", tag, p - 1), {31'd0, LD_VALID}, 32'd1);
         end
         tick();
         tick();
         tick();
      end
   endtask

   // Count clk from reset release until wr_ready; CK1 and one LINE_START are
   // thrown in and must be ignored.
   task automatic wait_init(input string tag);
      int n;
      n = 0;
      while (!wr_ready && n < 2000) begin
         CK1        = (n % 4 == 1);
         LINE_START = (n == 500);
         tick();
         n++;
      end
      CK1        = 1'b0;
      LINE_START = 1'b0;
      chk({tag, "_len"}, n, 1024);
      chk({tag, "_ld"}, {24'd0, LD}, 32'hFF);
      chk({tag, "_vld"}, {31'd0, LD_VALID}, 32'd0);
   endtask

   initial begin
      VIDEO_RSTn = 1'b0;
      CK1        = 1'b0;
      LINE_START = 1'b0;
      wr_valid   = 1'b0;
      wr_x       = '0;
      wr_data    = '0;
      tick();
      tick();
      tick();
      chk("rst_ld", {24'd0, LD}, 32'hFF);
      chk("rst_vld", {31'd0, LD_VALID}, 32'd0);
      chk("rst_ovf", {31'd0, OVF}, 32'd0);
      chk("rst_rdy", {31'd0, wr_ready}, 32'd0);

      VIDEO_RSTn = 1'b1;
      wait_init("init");

      // Opaque pixel and a transparent one
      wr(5, 8'h3A);
      wr(6, 8'h2F);
      line_start();
      fill_ff();
      exp_line[5] = 8'h3A;
      stream("basic", 1'b0);

      // Later write to the same x wins
      wr(10, 8'h12);
      wr(10, 8'h34);
      line_start();
      fill_ff();
      exp_line[10] = 8'h34;
      stream("ovwr", 1'b0);

      // Two empty lines: the second re-reads the bank streamed by "ovwr"
      line_start();
      fill_ff();
      stream("empty0", 1'b0);
      line_start();
      fill_ff();
      stream("clrbehind", 1'b0);

      // Budget: 144 writes off-screen first, then x=0..255; x=240..255 dropped
      wr_valid = 1'b1;
      for (int j = 0; j < 400; j++) begin
         int x;
         x       = (j < 144) ? 256 + j : j - 144;
         wr_x    = x[8:0];
         wr_data = pat(x);
         tick();
         if (j == 383) chk("ovf_at_384", {31'd0, OVF}, 32'd0);
         if (j == 384) chk("ovf_at_385", {31'd0, OVF}, 32'd1);
      end
      wr_valid = 1'b0;
      chk("ovf_sticky", {31'd0, OVF}, 32'd1);
      line_start();
      chk("ovf_clr", {31'd0, OVF}, 32'd0);
      fill_ff();
      for (int x = 0; x < 240; x++) exp_line[x] = pat(x);
      stream("budget", 1'b0);

      // LINE_START with wr_valid: the write must be refused
      LINE_START = 1'b1;
      wr_valid   = 1'b1;
      wr_x       = 9'd20;
      wr_data    = 8'h77;
      #1;
      chk("ls_wr_rdy", {31'd0, wr_ready}, 32'd0);
      tick();
      LINE_START = 1'b0;
      wr_valid   = 1'b0;
      fill_ff();
      stream("ls_wr", 1'b0);

      // LINE_START with CK1: that pulse reads RD_START of the new bank
      wr(0, 8'hC4);
      wr(1, 8'hD5);
      fill_ff();
      exp_line[0] = 8'hC4;
      exp_line[1] = 8'hD5;
      stream("ls_ck1", 1'b1);

      // Asynchronous reset in the middle of a line
      wr(3, 8'h66);
      line_start();
      wr_valid = 1'b1;
      wr_x     = 9'd300;
      wr_data  = 8'h11;
      for (int j = 0; j < 385; j++) tick();
      wr_valid = 1'b0;
      chk("mid_ovf", {31'd0, OVF}, 32'd1);
      for (int p = 0; p < 5; p++) begin
         CK1 = 1'b1;
         tick();
         CK1 = 1'b0;
         if (p == 4) begin
            chk("mid_px3", {24'd0, LD}, 32'h66);
            chk("mid_px3_vld", {31'd0, LD_VALID}, 32'd1);
         end
         tick();
         tick();
         tick();
      end
      VIDEO_RSTn = 1'b0;
      #2;
      chk("arst_ld", {24'd0, LD}, 32'hFF);
      chk("arst_vld", {31'd0, LD_VALID}, 32'd0);
      chk("arst_ovf", {31'd0, OVF}, 32'd0);
      chk("arst_rdy", {31'd0, wr_ready}, 32'd0);
      tick();
      tick();
      VIDEO_RSTn = 1'b1;
      wait_init("reinit");
      line_start();
      fill_ff();
      stream("post_rst", 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
